uart_bus_responder: RTL
=======================

# uart_bus_responder

Memory-mapped 8N1 UART peripheral that acts as a bus responder to the z80computer CPU bus (address, write data, read data, write-enable, chip-select, acknowledge). The CPU reaches the transmitter and receiver through four byte registers. Each direction has its own FIFO. An interrupt output can drive the CPU interrupt input. The block sits beside the SRAM on the system bus and owns the board pins `uart_tx` and `uart_rx`.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit. Must be ≥4.
- `FIFO_DEPTH`, 4: entries per FIFO. Must be a power of two, ≥2.
- `i_clk` in 1: single clock. All logic runs on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_addr` in 2: register offset; the CPU address is decoded upstream.
- `i_dat` in 8: write data.
- `o_dat` out 8: read data, valid while `o_ack`=1, otherwise 0.
- `i_we` in 1: 1 = write, 0 = read.
- `i_cs` in 1: access request.
- `o_ack` out 1: one-cycle acknowledge.
- `o_irq` out 1: level interrupt.
- `uart_rx` in 1: asynchronous serial input.
- `uart_tx` out 1: serial output, idles high.

## Operation
- Register map:
  - 0 DATA: write pushes to the TX FIFO; read pops the RX FIFO.
  - 1 STATUS (read-only):
    - b0 rx_avail
    - b1 tx_full
    - b2 tx_idle (FIFO empty and shifter idle)
    - b3 rx_overrun (sticky)
    - b4 frame_err (sticky)
  - 2 CTRL (R/W): b0 rx_ie, b1 txidle_ie.
  - 3: reads 0, writes ignored.
- Bus FSM:
  - IDLE: `i_cs`=1 accepts the access and goes to ACK.
  - ACK: `o_ack`=1 for exactly one cycle, then goes to RELEASE.
  - RELEASE: waits until `i_cs`=0, then goes to IDLE.
  - Side effects (push, pop, sticky clear) occur exactly once per `i_cs` assertion.
- Edge cases:
  - Write DATA while TX full: byte discarded, still acked.
  - Read DATA while RX empty: returns 0x00, no pop.
  - Read STATUS: returns current bits, then clears b3 and b4 in the same cycle.
- TX:
  - States TX_IDLE, START, DATA, STOP.
  - Loads from the FIFO whenever it is in TX_IDLE and the FIFO is non-empty.
  - Sends LSB first.
  - Each bit lasts CLKS_PER_BIT cycles.
- RX:
  - `uart_rx` passes through a 2-flop synchronizer.
  - States RX_IDLE, START, DATA, STOP.
  - Start is detected on the synchronized falling edge.
  - The start bit is re-checked at mid-bit (CLKS_PER_BIT/2). If it reads high, the start is treated as a glitch and the FSM returns to RX_IDLE.
  - Data bits are sampled at mid-bit.
  - Stop bit = 0: byte dropped and frame_err set.
  - RX FIFO full at the end of the stop bit: byte dropped and rx_overrun set.
- `o_irq` = (rx_ie & rx_avail) | (txidle_ie & tx_idle), registered.
- Reset values:
  - `o_ack`=0, `o_dat`=0, `o_irq`=0, `uart_tx`=1.
  - Both FIFOs empty, CTRL=0, sticky bits 0, all FSMs idle.
  - Reset mid-frame aborts TX immediately (line goes high) and discards any partial RX byte.

## Timing
- Access accepted at edge N gives `o_ack`/`o_dat` valid in cycle N+1.
- The FIFO push or pop commits at edge N+1.
- STATUS read in cycle N+1 reflects state before this access's own side effects.
- TX latency: push commits at edge P, FSM loads at P+1, `uart_tx` goes low from P+2.
- TX frame: 10·CLKS_PER_BIT cycles. Back-to-back bytes have no idle gap.
- RX latency: rx_avail goes to 1 at most 3 cycles after the nominal mid-stop-bit sample point (the 2-flop sync accounts for 2 of these).
- Simultaneous push and pop on a FIFO (bus plus shifter in the same cycle):
  - Both take effect.
  - A full FIFO accepts a push only when it is popped in the same cycle.
  - An empty FIFO never underflows.
- Counters:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.
  - FIFO pointers: $clog2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty.

## Structure
- Package `uart_bus_pkg` holds:
  - register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2)
  - STATUS/CTRL bit indices
  - TX/RX state enums.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty), instantiated twice.
- The TX/RX shifters and the bus FSM stay inline.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset, then idle for 50 cycles: `uart_tx`=1, `o_ack`=0, `o_irq`=0, STATUS reads 0x04.
- Write 0x55 to DATA: `o_ack` in the next cycle only. `uart_tx` shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, starting 2 cycles after the ack edge. STATUS b2 is 1 after 40 cycles.
- Drive frame 0xA3 on `uart_rx`, then read DATA → 0xA3. A second read returns 0x00 with rx_avail=0.
- Drive FIFO_DEPTH+1 frames (0x01..0x05) without reading:
  - STATUS reads 0x09 (rx_avail, overrun); a second STATUS read gives 0x01.
  - DATA reads return 0x01..0x04.
- Hold `i_cs`=1 for 6 cycles on a DATA write of 0x7E: exactly one ack, exactly one frame transmitted.
- Set CTRL=0x01, then receive 0x10: `o_irq` rises. Reading DATA drops `o_irq`. Also drive a frame with stop=0: the byte is dropped and STATUS b4 is set.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared register map, bit positions and state encodings for the UART bus responder.
package uart_bus_pkg;

  // Register offsets seen by the CPU
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_IDLE    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  // CTRL bit positions
  localparam int CTRL_RX_IE     = 0;
  localparam int CTRL_TXIDLE_IE = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_RELEASE} bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra MSB to tell full from empty.
// A full FIFO accepts a push only when it is popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both ends may move in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, a cs/ack bus responder and a level IRQ.
// Bus handshake: an access is accepted when i_cs is seen in BUS_IDLE; o_ack is high for
// exactly the following cycle (o_dat valid only then), and the FSM then waits for i_cs
// to drop, so each i_cs assertion produces one ack and one set of side effects.
module uart_bus_responder
  import uart_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_we,
  input  logic       i_cs,
  output logic       o_ack,
  output logic       o_irq,
  input  logic       uart_rx,
  output logic       uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  bus_state_t r_bus_state;
  tx_state_t  r_tx_state;
  rx_state_t  r_rx_state;

  logic [1:0]    r_addr;
  logic          r_we;
  logic [7:0]    r_wdat;
  logic [1:0]    r_ctrl;
  logic          r_overrun;
  logic          r_frame_err;
  logic          r_irq;
  logic          r_tx;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  logic       w_ack_cycle;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_idle;
  logic [7:0] w_tx_dout;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_done;
  logic [7:0] w_rx_dout;
  logic       w_status_rd, w_overrun_set, w_frame_set;
  logic [7:0] w_status;
  logic [7:0] w_rd_mux;

  assign w_ack_cycle   = (r_bus_state == BUS_ACK);
  assign w_tx_push     = w_ack_cycle & r_we & (r_addr == REG_DATA);
  assign w_rx_pop      = w_ack_cycle & ~r_we & (r_addr == REG_DATA);
  assign w_status_rd   = w_ack_cycle & ~r_we & (r_addr == REG_STATUS);
  assign w_tx_idle     = w_tx_empty & (r_tx_state == TX_IDLE);
  assign w_tx_pop      = ~w_tx_empty & ((r_tx_state == TX_IDLE) ||
                         ((r_tx_state == TX_STOP) && (r_tx_cnt == CNT_LAST)));
  assign w_rx_done     = (r_rx_state == RX_STOP) && (r_rx_cnt == CNT_LAST);
  assign w_rx_push     = w_rx_done & r_rx_s2;
  assign w_overrun_set = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_frame_set   = w_rx_done & ~r_rx_s2;

  assign o_ack   = w_ack_cycle;
  assign o_dat   = (w_ack_cycle && !r_we) ? w_rd_mux : 8'h00;
  assign o_irq   = r_irq;
  assign uart_tx = r_tx;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_din(r_wdat), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_din(r_rx_shift), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // STATUS word assembled from live state
  always_comb begin
    w_status                = 8'h00;
    w_status[ST_RX_AVAIL]   = ~w_rx_empty;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_TX_IDLE]    = w_tx_idle;
    w_status[ST_RX_OVERRUN] = r_overrun;
    w_status[ST_FRAME_ERR]  = r_frame_err;
  end

  // Read mux; evaluated in the ack cycle so it shows state before this access commits
  always_comb begin
    w_rd_mux = 8'h00;
    case (r_addr)
      REG_DATA:   w_rd_mux = w_rx_empty ? 8'h00 : w_rx_dout;
      REG_STATUS: w_rd_mux = w_status;
      REG_CTRL:   w_rd_mux = {6'b0, r_ctrl};
      default:    w_rd_mux = 8'h00;
    endcase
  end

  // Bus FSM, register side effects, sticky flags and the interrupt flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bus_state <= BUS_IDLE;
      r_addr      <= 2'd0;
      r_we        <= 1'b0;
      r_wdat      <= 8'h00;
      r_ctrl      <= 2'b00;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      case (r_bus_state)
        BUS_IDLE: if (i_cs) begin
          r_bus_state <= BUS_ACK;
          r_addr      <= i_addr;
          r_we        <= i_we;
          r_wdat      <= i_dat;
        end
        BUS_ACK:     r_bus_state <= BUS_RELEASE;
        BUS_RELEASE: if (!i_cs) r_bus_state <= BUS_IDLE;
        default:     r_bus_state <= BUS_IDLE;
      endcase
      if (w_ack_cycle && r_we && (r_addr == REG_CTRL)) r_ctrl <= r_wdat[1:0];
      // a new event on the clearing edge was not reported, so it must survive
      r_overrun   <= w_overrun_set | (r_overrun & ~w_status_rd);
      r_frame_err <= w_frame_set | (r_frame_err & ~w_status_rd);
      r_irq       <= (r_ctrl[CTRL_RX_IE] & ~w_rx_empty) |
                     (r_ctrl[CTRL_TXIDLE_IE] & w_tx_idle);
    end
  end

  // TX shifter; line level is registered from the current state, and the next byte is
  // loaded straight out of STOP so consecutive frames have no idle gap
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (!w_tx_empty) begin
            r_tx_shift <= w_tx_dout;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          r_tx <= 1'b0;
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_state <= TX_DATA;
          end else r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        TX_DATA: begin
          r_tx <= r_tx_shift[0];
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
          end else r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        TX_STOP: begin
          r_tx <= 1'b1;
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (!w_tx_empty) begin
              r_tx_shift <= w_tx_dout;
              r_tx_state <= TX_START;
            end else r_tx_state <= TX_IDLE;
          end else r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX synchronizer, start detection with mid-bit glitch check, mid-bit sampling
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == CNT_MID) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
